// File: rtl/handshake_arbiter_if.sv
// Requester-facing and channel-facing signals of the handshake arbiter.
// slave is the arbiter's view; master is the view of whoever drives requests and send_s.
interface handshake_arbiter_if #(
  parameter int WIDTH   = 7,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) ();
  logic [NUM_REQ-1:0]       req_valid_s;
  logic [NUM_REQ*WIDTH-1:0] req_data_s;
  logic [NUM_REQ-1:0]       req_ready_s;
  logic [NUM_REQ-1:0]       done_s;
  logic                     send_s;
  logic                     new_data_s;
  logic [WIDTH-1:0]         data_in_s;
  logic [ID_W-1:0]          grant_id_s;
  logic                     busy_s;
  logic                     error_s;

  modport master (
    output req_valid_s, req_data_s, send_s,
    input  req_ready_s, done_s, new_data_s, data_in_s, grant_id_s, busy_s, error_s
  );

  modport slave (
    input  req_valid_s, req_data_s, send_s,
    output req_ready_s, done_s, new_data_s, data_in_s, grant_id_s, busy_s, error_s
  );
endinterface

// File: rtl/handshake_arbiter.sv
// Round-robin arbiter sharing one handshake CDC channel among NUM_REQ requesters.
// Follows each crossing through send_s and raises a sticky error if send_s never falls.
module handshake_arbiter_lane (
  input  logic clk_s,
  input  logic reset_s,
  input  logic ready_d,
  input  logic done_d,
  output logic ready_q,
  output logic done_q
);
  always_ff @(posedge clk_s) begin
    if (!reset_s) begin
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end
endmodule

module handshake_arbiter #(
  parameter int WIDTH   = 7,
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 16,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input logic                clk_s,
  input logic                reset_s,
  handshake_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT_LOW, WAIT_HIGH} state_t;

  state_t                        state_q, state_d;
  logic [ID_W-1:0]               ptr_q, ptr_d, gid_q, gid_d, win_id;
  logic                          win_vld;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [WIDTH-1:0]              data_q, data_d;
  logic                          new_q, new_d, busy_q, busy_d, err_q, err_d;
  logic [NUM_REQ-1:0]            rdy_d, rdy_q, done_d, done_q;
  logic [NUM_REQ-1:0][WIDTH-1:0] req_data;

  assign req_data = bus.req_data_s;

  // Scan downward so the last hit is the one closest to ptr.
  always_comb begin
    logic [ID_W:0] idx;
    win_vld = 1'b0;
    win_id  = '0;
    idx     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
      if (bus.req_valid_s[idx[ID_W-1:0]]) begin
        win_vld = 1'b1;
        win_id  = idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    gid_d   = gid_q;
    busy_d  = busy_q;
    err_d   = err_q;
    new_d   = 1'b0;
    rdy_d   = '0;
    done_d  = '0;
    case (state_q)
      IDLE: begin
        if (bus.send_s && win_vld) begin
          data_d         = req_data[win_id];
          new_d          = 1'b1;
          rdy_d[win_id]  = 1'b1;
          gid_d          = win_id;
          busy_d         = 1'b1;
          ptr_d          = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
          cnt_d          = '0;
          state_d        = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!bus.send_s) begin
          cnt_d   = '0;
          state_d = WAIT_HIGH;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Channel never took the word: abort without a completion pulse.
          err_d   = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (bus.send_s) begin
          done_d[gid_q] = 1'b1;
          busy_d        = 1'b0;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_s) begin
    if (!reset_s) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      gid_q   <= '0;
      new_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      gid_q   <= gid_d;
      new_q   <= new_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    handshake_arbiter_lane u_lane (
      .clk_s   (clk_s),
      .reset_s (reset_s),
      .ready_d (rdy_d[i]),
      .done_d  (done_d[i]),
      .ready_q (rdy_q[i]),
      .done_q  (done_q[i])
    );
  end

  assign bus.req_ready_s = rdy_q;
  assign bus.done_s      = done_q;
  assign bus.new_data_s  = new_q;
  assign bus.data_in_s   = data_q;
  assign bus.grant_id_s  = gid_q;
  assign bus.busy_s      = busy_q;
  assign bus.error_s     = err_q;
endmodule

// File: tb/tb_handshake_arbiter.sv
// Randomized scoreboard bench for handshake_arbiter: the stimulus pushes expected
// grants/completions, a negedge monitor pops and compares them.
module tb_handshake_arbiter;
  localparam int WIDTH   = 7;
  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 16;
  localparam int ID_W    = 2;

  logic clk_s   = 1'b0;
  logic reset_s = 1'b0;

  handshake_arbiter_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  handshake_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT), .ID_W(ID_W)) dut (
    .clk_s   (clk_s),
    .reset_s (reset_s),
    .bus     (bus)
  );

  always #5 clk_s = ~clk_s;

  typedef struct {
    int               id;
    logic [WIDTH-1:0] data;
  } xfer_t;

  xfer_t            grant_q[$];
  xfer_t            done_q[$];
  int               n_chk  = 0;
  int               n_pass = 0;
  bit               mon_en = 1'b0;
  bit [NUM_REQ-1:0] pend;
  logic [WIDTH-1:0] pdata[NUM_REQ];
  int               m_ptr;
  bit               m_err;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic drive_reqs();
    bus.req_valid_s = pend;
    for (int i = 0; i < NUM_REQ; i++) bus.req_data_s[i*WIDTH +: WIDTH] = pdata[i];
  endtask

  task automatic add_req(input int i, input logic [WIDTH-1:0] d);
    if (!pend[i]) begin
      pend[i]  = 1'b1;
      pdata[i] = d;
    end
  endtask

  // Reference: first pending requester at or after the pointer, wrapping.
  function automatic int rr_pick(input bit [NUM_REQ-1:0] p, input int ptr);
    for (int k = 0; k < NUM_REQ; k++)
      if (p[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    return -1;
  endfunction

  always @(negedge clk_s) begin
    if (mon_en) begin
      xfer_t e;
      if (grant_q.size() == 0) begin
        chk("new_data_idle", 32'(bus.new_data_s), 0);
        chk("ready_idle", 32'(bus.req_ready_s), 0);
      end else if (bus.new_data_s === 1'b1) begin
        e = grant_q.pop_front();
        chk("grant_id", 32'(bus.grant_id_s), e.id);
        chk("grant_ready", 32'(bus.req_ready_s), 1 << e.id);
        chk("grant_data", 32'(bus.data_in_s), 32'(e.data));
        chk("grant_busy", 32'(bus.busy_s), 1);
      end
      if (done_q.size() == 0) begin
        chk("done_idle", 32'(bus.done_s), 0);
      end else if (bus.done_s !== '0) begin
        e = done_q.pop_front();
        chk("done_onehot", 32'(bus.done_s), 1 << e.id);
        chk("done_busy", 32'(bus.busy_s), 0);
        chk("done_data_hold", 32'(bus.data_in_s), 32'(e.data));
        chk("error_sticky", 32'(bus.error_s), 32'(m_err));
      end
    end
  end

  initial begin
    xfer_t e;
    int    w, mode, d, l;
    bus.req_valid_s = '0;
    bus.req_data_s  = '0;
    bus.send_s      = 1'b1;
    pend            = '0;
    for (int i = 0; i < NUM_REQ; i++) pdata[i] = '0;
    m_ptr = 0;
    m_err = 1'b0;

    repeat (2) @(posedge clk_s);
    @(negedge clk_s);
    chk("rst_new_data", 32'(bus.new_data_s), 0);
    chk("rst_ready", 32'(bus.req_ready_s), 0);
    chk("rst_done", 32'(bus.done_s), 0);
    chk("rst_busy", 32'(bus.busy_s), 0);
    chk("rst_error", 32'(bus.error_s), 0);
    chk("rst_grant_id", 32'(bus.grant_id_s), 0);
    chk("rst_data_in", 32'(bus.data_in_s), 0);
    reset_s = 1'b1;
    mon_en  = 1'b1;

    for (int it = 0; it < 60; it++) begin
      // DUT is idle here; the next posedge decides whether to issue.
      if (it == 0) add_req(2, 7'h15);
      else if (it == 1) begin
        add_req(1, WIDTH'($urandom));
        add_req(3, WIDTH'($urandom));
      end else if (it >= 3) begin
        for (int i = 0; i < NUM_REQ; i++)
          if ($urandom_range(1, 0) == 1) add_req(i, WIDTH'($urandom));
      end
      if (pend == '0) add_req($urandom_range(NUM_REQ - 1, 0), WIDTH'($urandom));

      if (it == 5 || (it > 5 && $urandom_range(3, 0) == 0)) begin
        bus.send_s = 1'b0;
        drive_reqs();
        repeat ($urandom_range(4, 1)) begin
          @(posedge clk_s);
          #1;
        end
      end
      bus.send_s = 1'b1;
      drive_reqs();

      w      = rr_pick(pend, m_ptr);
      e.id   = w;
      e.data = pdata[w];
      grant_q.push_back(e);
      m_ptr  = (w + 1) % NUM_REQ;

      @(posedge clk_s);
      #1;
      pend[w]  = 1'b0;
      pdata[w] = WIDTH'($urandom);
      drive_reqs();
      @(negedge clk_s);
      #1;
      chk("grant_latency", 32'(grant_q.size()), 0);
      grant_q.delete();

      if (it < 3) mode = 2;
      else if (it == 4) mode = 0;
      else if (it == 6) mode = 1;
      else mode = $urandom_range(7, 0);

      if (mode == 0) begin
        for (int c = 1; c <= TIMEOUT; c++) begin
          @(negedge clk_s);
          if (c == TIMEOUT - 1) begin
            chk("wd_error_before", 32'(bus.error_s), 32'(m_err));
            chk("wd_busy_before", 32'(bus.busy_s), 1);
          end else if (c == TIMEOUT) begin
            chk("wd_error", 32'(bus.error_s), 1);
            chk("wd_busy", 32'(bus.busy_s), 0);
          end
        end
        m_err = 1'b1;
        #1;
      end else begin
        d = $urandom_range(3, 0);
        repeat (d) begin
          @(posedge clk_s);
          #1;
        end
        bus.send_s = 1'b0;
        l = $urandom_range(5, 1);
        repeat (l) begin
          @(posedge clk_s);
          #1;
          if (it >= 3 && $urandom_range(2, 0) == 0) begin
            add_req($urandom_range(NUM_REQ - 1, 0), WIDTH'($urandom));
            drive_reqs();
          end
        end
        if (mode == 1) begin
          reset_s = 1'b0;
          @(posedge clk_s);
          #1;
          reset_s = 1'b1;
          @(negedge clk_s);
          chk("mid_rst_new_data", 32'(bus.new_data_s), 0);
          chk("mid_rst_ready", 32'(bus.req_ready_s), 0);
          chk("mid_rst_busy", 32'(bus.busy_s), 0);
          chk("mid_rst_error", 32'(bus.error_s), 0);
          chk("mid_rst_grant_id", 32'(bus.grant_id_s), 0);
          chk("mid_rst_data_in", 32'(bus.data_in_s), 0);
          m_ptr = 0;
          m_err = 1'b0;
          #1;
        end else begin
          bus.send_s = 1'b1;
          done_q.push_back(e);
          @(posedge clk_s);
          @(negedge clk_s);
          #1;
          chk("done_latency", 32'(done_q.size()), 0);
          done_q.delete();
        end
      end
    end

    pend = '0;
    drive_reqs();
    repeat (3) @(posedge clk_s);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/handshake_arbiter.md
Name: handshake_arbiter

Overview:
Source-domain arbiter that shares one `handshake` CDC channel among NUM_REQ requesters, using round-robin order. It sits in front of the handshake block's source side. It drives `new_data_s` and `data_in_s`, and watches `send_s` to follow each transfer through its crossing. Data is held stable for the whole crossing, each requester gets a completion pulse, and a sticky watchdog error is raised if the channel stalls.

Parameters:
WIDTH, 7, data word width; matches the handshake WIDTH.
NUM_REQ, 4, number of requesters; must be >= 1.
TIMEOUT, 16, cycles allowed in WAIT_LOW for `send_s` to fall after issue; must be >= 2.
ID_W, $clog2(NUM_REQ) with minimum 1, width of the grant index (derived).

Ports:
clk_s  in  1  source-domain clock; all logic on posedge.
reset_s  in  1  synchronous, active-low reset.
req_valid_s  in  NUM_REQ  per-requester request; must stay high with stable data until `req_ready_s[i]`.
req_data_s  in  NUM_REQ*WIDTH  packed request data; requester i uses bits [i*WIDTH +: WIDTH].
req_ready_s  out  NUM_REQ  one-cycle accept pulse to the granted requester.
done_s  out  NUM_REQ  one-cycle pulse when the granted transfer's crossing completes.
send_s  in  1  from the handshake: 1 = channel idle and ready.
new_data_s  out  1  one-cycle load strobe to the handshake.
data_in_s  out  WIDTH  data to the handshake; held until the next grant.
grant_id_s  out  ID_W  index of the current or most recent grant.
busy_s  out  1  high from issue until completion or abort.
error_s  out  1  sticky watchdog flag; cleared only by reset.

Behaviour:
- All outputs are registered. No combinational path from inputs to outputs.
- Reset (`reset_s` = 0 at posedge):
  - State goes to IDLE, the round-robin pointer goes to 0, the watchdog counter goes to 0.
  - `req_ready_s`, `done_s`, `new_data_s`, `busy_s`, `error_s`, `grant_id_s` and `data_in_s` all go to 0.
  - Reset mid-transfer aborts the transfer with no `done_s` pulse. The requester is not re-served, because its `req_ready_s` has already fired.
- IDLE:
  - Waits for `send_s` = 1 and any `req_valid_s` bit set.
  - Winner g is the first set bit scanning ptr, ptr+1, ..., wrapping modulo NUM_REQ.
  - At that edge, registers: `data_in_s` <= slice g, `new_data_s` <= 1, `req_ready_s[g]` <= 1, `grant_id_s` <= g, `busy_s` <= 1, ptr <= (g+1) mod NUM_REQ. State goes to WAIT_LOW.
  - If `send_s` = 0, nothing issues and the state stays IDLE.
- Pulse widths: `new_data_s` and `req_ready_s[g]` are high for exactly one cycle, the same cycle. That cycle is the transfer-accept cycle.
- WAIT_LOW:
  - Waits for `send_s` = 0, then goes to WAIT_HIGH and clears the counter.
  - The counter increments each cycle in this state.
  - When the counter reaches TIMEOUT-1 with `send_s` still 1: `error_s` <= 1, `busy_s` <= 0, no `done_s`, state goes to IDLE.
- WAIT_HIGH:
  - Waits for `send_s` = 1, then: `done_s[grant_id_s]` <= 1 for one cycle, `busy_s` <= 0, state goes to IDLE.
  - There is no timeout here, because the destination clock may be arbitrarily slow.
- Latency:
  - Request seen in IDLE → `new_data_s` is one cycle later.
  - `send_s` rising → `done_s` is one cycle later.
  - `done_s` → next `new_data_s` is at least one further cycle.
- Data hold: `data_in_s` is unchanged from issue until the next grant. Changes to `req_data_s` after accept are ignored.
- Priority: the requester just served has lowest priority next. No requester waits more than NUM_REQ-1 other grants.
- Simultaneous events: new requests arriving while busy are held off; `req_ready_s` stays 0.
- NUM_REQ = 1: the pointer stays 0 and `grant_id_s` is always 0.
- `error_s` does not block further grants.

Test Plan:
- Single requester: req 2 valid with data 0x15, `send_s` = 1, NUM_REQ = 4 → next cycle `new_data_s` = 1, `req_ready_s` = 4'b0100, `data_in_s` = 0x15, `grant_id_s` = 2. `send_s` low then high → `done_s` = 4'b0100 one cycle after `send_s` rises; `busy_s` clears.
- All four requesters continuously valid, data = index → grant order 0, 1, 2, 3, 0, and no second grant before the prior `done_s`.
- Pointer wrap and skip: ptr = 3, only requesters 1 and 3 valid → grant 3, then grant 1.
- Watchdog: issue, then hold `send_s` = 1 for 16 cycles → `error_s` = 1 on cycle 16, `busy_s` = 0, no `done_s`. A later request is still granted and `error_s` stays 1.
- Reset mid-transfer in WAIT_HIGH: `reset_s` = 0 for one cycle → all outputs 0 and ptr = 0. After `send_s` returns to 1, a request from requester 1 is granted normally.
- Channel held busy: requests pending with `send_s` = 0 in IDLE → no `new_data_s` and no `req_ready_s` until `send_s` = 1.
